uart_char_buffer: RTL and testbench
===================================

UART_CHAR_BUFFER -- requirements
Module: uart_char_buffer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417: cclk cycles per UART bit.
REQ-002 Parameter NUM_CHARS, default 26: display character slots.
REQ-003 Parameter CHAR_W, default 8: data bits per frame and per slot.
REQ-004 Parameter SPACE_CODE, default 27: fill code for empty slots.
REQ-005 Parameters BS_CODE, default 8'h08, and CLR_CODE, default 8'h0C: backspace and clear command codes.
REQ-006 cclk  input  1: the single clock; all logic rising-edge.
REQ-007 rst  input  1: asynchronous, active-high reset.
REQ-008 rx  input  1: asynchronous UART line, idles high.
REQ-009 rd_idx  input  $clog2(NUM_CHARS): display slot select; 0 is oldest, NUM_CHARS-1 is newest.
REQ-010 rd_char  output  CHAR_W: combinational contents of slot rd_idx.
REQ-011 rx_valid  output  1: one-cycle pulse per good frame.
REQ-012 rx_char  output  CHAR_W: last good byte, held until the next one.
REQ-013 frame_err  output  1: one-cycle pulse on bad stop bit.
REQ-014 busy  output  1: high while a clear sweep runs.

Function
REQ-015 rx shall pass a 2-FF synchronizer; all decisions use the synchronized value.
REQ-016 RX FSM states: IDLE, START, DATA, STOP; one bit-timer, one bit-index counter.
REQ-017 IDLE->START on synchronized high-to-low edge only; bit-timer cleared.
REQ-018 START: at timer = CLKS_PER_BIT/2-1, sample; low -> DATA with timer cleared; high -> IDLE (glitch, no pulse).
REQ-019 DATA: sample every CLKS_PER_BIT cycles, LSB first, CHAR_W bits, then STOP.
REQ-020 STOP: sample after CLKS_PER_BIT; high -> commit; low -> frame_err pulse, byte discarded, IDLE.
REQ-021 Commit: rx_valid and new rx_char in the cycle after the stop sample; buffer update on that same edge.
REQ-022 Buffer: NUM_CHARS-entry ring with head pointer; slot i maps to mem[(head+i) mod NUM_CHARS].
REQ-023 Ordinary byte: mem[head] <= byte, head+1 mod NUM_CHARS; new byte appears at slot NUM_CHARS-1, all others shift toward 0, oldest dropped.
REQ-024 BS_CODE: head-1 mod NUM_CHARS and mem[head-1] <= SPACE_CODE; newest dropped, slot 0 becomes SPACE_CODE.
REQ-025 CLR_CODE: busy rises next cycle; one entry written SPACE_CODE per cycle for NUM_CHARS cycles; head <= 0; then busy falls.
REQ-026 rx_valid shall pulse for BS_CODE and CLR_CODE as for data.
REQ-027 The RX FSM keeps running during busy; NUM_CHARS < CLKS_PER_BIT*(CHAR_W+2) is a parameter legality rule, checked by elaboration assertion, so no commit overlaps a sweep.
REQ-028 rd_char shall equal SPACE_CODE for rd_idx >= NUM_CHARS.
REQ-029 Pointer wrap shall use explicit compare, not power-of-two masking.

Reset
REQ-030 On rst: FSM IDLE, counters 0, synchronizer stages 1, head 0, all mem SPACE_CODE.
REQ-031 On rst: rx_valid 0, frame_err 0, busy 0, rx_char SPACE_CODE.
REQ-032 Reset mid-frame or mid-sweep aborts with no pulse; first frame after release needs a fresh falling edge.

Structure
REQ-033 Shared package holds SPACE_CODE, BS_CODE, CLR_CODE defaults and the RX state enum.
REQ-034 Sub-module uart_rx_core (synchronizer + FSM) shall output byte/valid/frame_err; uart_char_buffer owns the ring and sweep.

Verification (CLKS_PER_BIT=16, NUM_CHARS=4)
REQ-035 After reset, send 'A','B','C','D','E' -> slots 0..3 = 'B','C','D','E'; five rx_valid pulses, frame_err 0.
REQ-036 Then send BS_CODE -> slots = 27,'B','C','D'; rx_char = 8'h08.
REQ-037 Send frame 8'h55 with stop bit low -> frame_err one cycle, no rx_valid, slots unchanged.
REQ-038 Drive 5-cycle low glitch on idle rx -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-039 Send CLR_CODE -> busy high exactly 4 cycles, then all slots 27; next byte 'Z' -> slot 3 = 'Z'.
REQ-040 Assert rst during DATA of 'Q' -> slots all 27, no pulses; next full frame 'R' lands in slot 3.

Source files
------------

// File: rtl/uart_char_buffer_pkg.sv
// Shared constants and types for the UART character buffer: default
// command/fill codes and the receiver state encoding.
package uart_char_buffer_pkg;

  localparam int unsigned SPACE_CODE_DEF = 27;
  localparam int unsigned BS_CODE_DEF    = 8'h08;
  localparam int unsigned CLR_CODE_DEF   = 8'h0C;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_char_buffer_rx_core.sv
// UART receiver: 2-FF synchronizer on the line, then a start/data/stop
// FSM sharing one bit timer and one bit index. Produces a registered byte
// with a one-cycle valid pulse, or a one-cycle frame error pulse.
module uart_rx_core
  import uart_char_buffer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned IDLE_CHAR    = SPACE_CODE_DEF
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              rx,
  output logic [CHAR_W-1:0] rx_byte,
  output logic              valid,
  output logic              frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(CHAR_W + 1);
  localparam logic [TW-1:0] HALF_T   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_T   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAR_W - 1);

  logic              sync1, sync2, rx_prev;
  rx_state_t         state, next_state;
  logic [TW-1:0]     timer, timer_next;
  logic [BW-1:0]     bit_idx, bit_next;
  logic [CHAR_W-1:0] shift, shift_next, byte_next;
  logic              valid_next, ferr_next;

  // Synchronize the asynchronous line and keep one more stage for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // State, counters, shift register and the registered result outputs.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= CHAR_W'(IDLE_CHAR);
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= next_state;
      timer     <= timer_next;
      bit_idx   <= bit_next;
      shift     <= shift_next;
      rx_byte   <= byte_next;
      valid     <= valid_next;
      frame_err <= ferr_next;
    end
  end

  // Next-state and datapath decisions, all on the synchronized line value.
  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    next_state = state;
    timer_next = timer + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    byte_next  = rx_byte;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        timer_next = '0;
        bit_next   = '0;
        if (rx_prev && !sync2) next_state = RX_START;
      end
      RX_START: begin
        if (timer == HALF_T) begin
          timer_next = '0;
          next_state = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (timer == FULL_T) begin
          timer_next = '0;
          shift_next = {sync2, shift[CHAR_W-1:1]};
          if (bit_idx == LAST_BIT) begin
            bit_next   = '0;
            next_state = RX_STOP;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (timer == FULL_T) begin
          timer_next = '0;
          next_state = RX_IDLE;
          if (sync2) begin
            valid_next = 1'b1;
            byte_next  = shift;
          end else begin
            ferr_next = 1'b1;
          end
        end
      end
      default: next_state = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_char_buffer.sv
// Character display buffer fed by a UART receiver. A ring of NUM_CHARS
// slots scrolls left on each byte; backspace and clear codes edit it.
// Slot 0 is the oldest character, slot NUM_CHARS-1 the newest.
module uart_char_buffer
  import uart_char_buffer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned NUM_CHARS    = 26,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned SPACE_CODE   = SPACE_CODE_DEF,
  parameter int unsigned BS_CODE      = BS_CODE_DEF,
  parameter int unsigned CLR_CODE     = CLR_CODE_DEF
) (
  input  logic                         cclk,
  input  logic                         rst,
  input  logic                         rx,
  input  logic [$clog2(NUM_CHARS)-1:0] rd_idx,
  output logic [CHAR_W-1:0]            rd_char,
  output logic                         rx_valid,
  output logic [CHAR_W-1:0]            rx_char,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_CHARS);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_CHARS - 1);
  localparam logic [IW:0]       N_EXT    = (IW + 1)'(NUM_CHARS);
  localparam logic [CHAR_W-1:0] SPACE_C  = CHAR_W'(SPACE_CODE);
  localparam logic [CHAR_W-1:0] BS_C     = CHAR_W'(BS_CODE);
  localparam logic [CHAR_W-1:0] CLR_C    = CHAR_W'(CLR_CODE);

  // A sweep must finish before the next frame can possibly commit.
  if (NUM_CHARS >= CLKS_PER_BIT * (CHAR_W + 2)) begin : g_bad_params
    $error("uart_char_buffer: NUM_CHARS must be less than CLKS_PER_BIT*(CHAR_W+2)");
  end

  logic [CHAR_W-1:0] mem [NUM_CHARS];
  logic [IW-1:0]     head, head_inc, head_dec, sweep_idx, rd_phys;
  logic [IW:0]       rd_sum;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CHAR_W       (CHAR_W),
    .IDLE_CHAR    (SPACE_CODE)
  ) u_rx (
    .cclk      (cclk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (rx_char),
    .valid     (rx_valid),
    .frame_err (frame_err)
  );

  // Ring pointer neighbours, wrapped by explicit compare so any NUM_CHARS works.
  always_comb begin
    head_inc = (head == LAST_IDX) ? '0 : head + 1'b1;
    head_dec = (head == '0) ? LAST_IDX : head - 1'b1;
  end

  // Logical slot to physical entry; out-of-range slots read as blank.
  always_comb begin
    rd_sum  = {1'b0, head} + {1'b0, rd_idx};
    rd_phys = (rd_sum >= N_EXT) ? IW'(rd_sum - N_EXT) : rd_sum[IW-1:0];
    rd_char = ({1'b0, rd_idx} >= N_EXT) ? SPACE_C : mem[rd_phys];
  end

  // Apply committed bytes to the ring, or step the clear sweep one entry per cycle.
  // NOTE: the character array is reset entry by entry because a blank display after reset is required behaviour.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      busy      <= 1'b0;
      sweep_idx <= '0;
      for (int i = 0; i < NUM_CHARS; i++) mem[i] <= SPACE_C;
    end else if (busy) begin
      mem[sweep_idx] <= SPACE_C;
      if (sweep_idx == LAST_IDX) begin
        busy      <= 1'b0;
        sweep_idx <= '0;
      end else begin
        sweep_idx <= sweep_idx + 1'b1;
      end
    end else if (rx_valid) begin
      if (rx_char == CLR_C) begin
        busy      <= 1'b1;
        head      <= '0;
        sweep_idx <= '0;
      end else if (rx_char == BS_C) begin
        head           <= head_dec;
        mem[head_dec]  <= SPACE_C;
      end else begin
        mem[head] <= rx_char;
        head      <= head_inc;
      end
    end
  end

endmodule

// File: tb/tb_uart_char_buffer.sv
// Self-checking bench for uart_char_buffer with 16 clocks per bit and a
// 4-slot display. A reference model keeps the display as a plain array
// and scrolls it according to the character rules.
module tb_uart_char_buffer;

  localparam int CPB = 16;
  localparam int N   = 4;
  localparam logic [7:0] SP  = 8'd27;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] CLR = 8'h0C;

  logic       cclk = 1'b0;
  logic       rst  = 1'b1;
  logic       rx   = 1'b1;
  logic [1:0] rd_idx = '0;
  logic [7:0] rd_char, rx_char;
  logic       rx_valid, frame_err, busy;

  int checks = 0;
  int errors = 0;

  int valid_cnt = 0, ferr_cnt = 0, busy_cyc = 0;
  int exp_valid = 0, exp_ferr = 0, exp_busy = 0;
  logic [7:0] exp_char = SP;
  logic [7:0] model [N];

  uart_char_buffer #(
    .CLKS_PER_BIT (CPB),
    .NUM_CHARS    (N),
    .CHAR_W       (8)
  ) dut (
    .cclk      (cclk),
    .rst       (rst),
    .rx        (rx),
    .rd_idx    (rd_idx),
    .rd_char   (rd_char),
    .rx_valid  (rx_valid),
    .rx_char   (rx_char),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 cclk = ~cclk;

  // Count output pulses and busy cycles away from the active edge.
  always @(negedge cclk) begin
    if (!rst) begin
      if (rx_valid)  valid_cnt++;
      if (frame_err) ferr_cnt++;
      if (busy)      busy_cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) model[i] = SP;
  endtask

  // Display rules in terms of logical slots: scroll left, scroll right, or blank.
  task automatic model_commit(input logic [7:0] b);
    exp_valid++;
    exp_char = b;
    if (b == CLR) begin
      model_clear();
      exp_busy += N;
    end else if (b == BS) begin
      for (int i = N - 1; i > 0; i--) model[i] = model[i-1];
      model[0] = SP;
    end else begin
      for (int i = 0; i < N - 1; i++) model[i] = model[i+1];
      model[N-1] = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
    if (stop_bit) model_commit(b);
    else exp_ferr++;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("%s_slot%0d", tag, i), rd_char, model[i]);
    end
    check({tag, "_nvalid"}, valid_cnt, exp_valid);
    check({tag, "_nferr"},  ferr_cnt,  exp_ferr);
    check({tag, "_rxchar"}, rx_char,   exp_char);
    check({tag, "_busycyc"}, busy_cyc, exp_busy);
    check({tag, "_busy"},   busy,      1'b0);
  endtask

  initial begin
    logic [7:0] q, b;
    int r;
    model_clear();
    tick(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    tick(5);
    check_all("reset");

    // Fill and overflow the display by one character.
    for (int c = 0; c < 5; c++) send_frame(8'(8'h41 + c), 1'b1);
    check_all("abcde");

    send_frame(BS, 1'b1);
    check_all("bs");

    send_frame(8'h55, 1'b0);
    check_all("stoperr");

    // Short low glitch on an idle line must be rejected.
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CPB);
    check_all("glitch");
    send_frame(8'h47, 1'b1);
    check_all("after_glitch");

    send_frame(CLR, 1'b1);
    check_all("clr");
    send_frame(8'h5A, 1'b1);
    check_all("z");

    // Reset in the middle of the data bits of 'Q'.
    q  = 8'h51;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = q[i];
      tick(CPB);
    end
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    rst = 1'b0;
    model_clear();
    exp_char = SP;
    tick(12 * CPB);
    check_all("midreset");
    send_frame(8'h52, 1'b1);
    check_all("r");

    // Random mix of characters, edits and framing errors.
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 15);
      b = 8'($urandom);
      if (r == 0)      b = CLR;
      else if (r < 3)  b = BS;
      else if (b == BS || b == CLR) b = 8'h30;
      send_frame(b, (r == 3 || r == 4) ? 1'b0 : 1'b1);
      check_all($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
